// File: rtl/csr_timer_pkg.sv
// Shared register indices and bit positions for the csr_timer CSR block.
package csr_timer_pkg;

    typedef logic [9:0] reg_idx_t;

    localparam reg_idx_t REG_CTRL     = 10'd0;
    localparam reg_idx_t REG_RELOAD   = 10'd1;
    localparam reg_idx_t REG_COUNTER  = 10'd2;
    localparam reg_idx_t REG_STATUS   = 10'd3;
    localparam reg_idx_t REG_PRESCALE = 10'd4;
    localparam reg_idx_t REG_CAPTURE  = 10'd5;

    localparam int unsigned CTRL_W          = 3;
    localparam int unsigned CTRL_EN         = 0;
    localparam int unsigned CTRL_AUTORELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN     = 2;

    localparam int unsigned STAT_W        = 3;
    localparam int unsigned STAT_EVENT    = 0;
    localparam int unsigned STAT_OVERRUN  = 1;
    localparam int unsigned STAT_CAPTURED = 2;

    function automatic logic csr_selected(input logic [13:0] a, input logic [3:0] base);
        return a[13:10] == base;
    endfunction

endpackage

// File: rtl/csr_timer_prescaler.sv
// Prescale down-counter: emits a one-cycle tick every (prescale+1) cycles while enabled.
module csr_timer_prescaler
    import csr_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] load_val,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        tick   = 1'b0;
        if (!en) begin
            pcnt_d = prescale;
        end else if (pcnt_q == '0) begin
            tick   = 1'b1;
            pcnt_d = prescale;
        end else begin
            pcnt_d = pcnt_q - PRESCALE_W'(1);
        end
        // A PRESCALE write restarts the period with the freshly written value
        if (load) begin
            pcnt_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/csr_timer.sv
// CSR-bus 32-bit down-counting timer with prescaler, auto-reload and level irq.
// Optional input capture register is enabled by defining CSR_TIMER_CAPTURE_EN.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter logic [3:0]  csr_addr   = 4'h0,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
`ifdef CSR_TIMER_CAPTURE_EN
    input  logic        capture_i,
`endif
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq
);

    logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
    logic [31:0]           reload_q,   reload_d;
    logic [31:0]           counter_q,  counter_d;
    logic [STAT_W-1:0]     status_q,   status_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           csr_do_q,   csr_do_d;
    logic                  irq_q,      irq_d;

    logic     sel;
    reg_idx_t idx;
    logic     wr_ctrl, wr_reload, wr_counter, wr_status, wr_prescale;
    logic     tick;
    logic     evt;

`ifdef CSR_TIMER_CAPTURE_EN
    logic [31:0] capture_q, capture_d;
    logic        cap_prev_q;
    logic        cap_rise;
    assign cap_rise = capture_i & ~cap_prev_q;
`endif

    assign sel         = csr_selected(csr_a, csr_addr);
    assign idx         = csr_a[9:0];
    assign wr_ctrl     = sel && csr_we && (idx == REG_CTRL);
    assign wr_reload   = sel && csr_we && (idx == REG_RELOAD);
    assign wr_counter  = sel && csr_we && (idx == REG_COUNTER);
    assign wr_status   = sel && csr_we && (idx == REG_STATUS);
    assign wr_prescale = sel && csr_we && (idx == REG_PRESCALE);

    csr_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .en       (ctrl_q[CTRL_EN]),
        .prescale (prescale_q),
        .load     (wr_prescale),
        .load_val (csr_di[PRESCALE_W-1:0]),
        .tick     (tick)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        reload_d   = reload_q;
        counter_d  = counter_q;
        status_d   = status_q;
        prescale_d = prescale_q;
        csr_do_d   = '0;
        evt        = 1'b0;
`ifdef CSR_TIMER_CAPTURE_EN
        capture_d  = capture_q;
`endif

        if (tick) begin
            if (counter_q != '0) begin
                counter_d = counter_q - 32'd1;
            end else begin
                evt = 1'b1;
                if (ctrl_q[CTRL_AUTORELOAD]) begin
                    counter_d = reload_q;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        end

        // A CTRL or COUNTER write drops the tick's counter/EN update entirely;
        // the event itself is still recorded in STATUS below.
        if (wr_ctrl || wr_counter) begin
            ctrl_d    = ctrl_q;
            counter_d = counter_q;
        end
        if (wr_ctrl)     ctrl_d     = csr_di[CTRL_W-1:0];
        if (wr_reload)   reload_d   = csr_di;
        if (wr_counter)  counter_d  = csr_di;
        if (wr_prescale) prescale_d = csr_di[PRESCALE_W-1:0];
        if (wr_status)   status_d   = status_q & ~csr_di[STAT_W-1:0];

        // Overrun only when the previous EVENT survives this cycle's W1C
        if (evt) begin
            if (status_d[STAT_EVENT]) begin
                status_d[STAT_OVERRUN] = 1'b1;
            end
            status_d[STAT_EVENT] = 1'b1;
        end

`ifdef CSR_TIMER_CAPTURE_EN
        if (cap_rise) begin
            capture_d               = counter_q;
            status_d[STAT_CAPTURED] = 1'b1;
        end
`endif

        irq_d = status_d[STAT_EVENT] & ctrl_d[CTRL_IRQ_EN];

        if (sel) begin
            case (idx)
                REG_CTRL:     csr_do_d = 32'(ctrl_q);
                REG_RELOAD:   csr_do_d = reload_q;
                REG_COUNTER:  csr_do_d = counter_q;
                REG_STATUS:   csr_do_d = 32'(status_q);
                REG_PRESCALE: csr_do_d = 32'(prescale_q);
`ifdef CSR_TIMER_CAPTURE_EN
                REG_CAPTURE:  csr_do_d = capture_q;
`endif
                default:      csr_do_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ctrl_q     <= '0;
            reload_q   <= '0;
            counter_q  <= '0;
            status_q   <= '0;
            prescale_q <= '0;
            csr_do_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            reload_q   <= reload_d;
            counter_q  <= counter_d;
            status_q   <= status_d;
            prescale_q <= prescale_d;
            csr_do_q   <= csr_do_d;
            irq_q      <= irq_d;
        end
    end

`ifdef CSR_TIMER_CAPTURE_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            capture_q  <= '0;
            cap_prev_q <= 1'b0;
        end else begin
            capture_q  <= capture_d;
            cap_prev_q <= capture_i;
        end
    end
`endif

    assign csr_do = csr_do_q;
    assign irq    = irq_q;

endmodule
